// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 timing/control blocks.
package sap1_pkg;

  localparam int T_STATES_DEFAULT = 6;

  // Width of a binary index able to address n one-hot positions (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // What the ring does on the coming edge, in priority order below reset.
  typedef enum logic [2:0] {
    ACT_FIX    = 3'd0,
    ACT_HALTED = 3'd1,
    ACT_HOLD   = 3'd2,
    ACT_WRAP   = 3'd3,
    ACT_SHIFT  = 3'd4
  } ring_act_e;

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with a legality flag (exactly one bit set).
module onehot_enc
  import sap1_pkg::*;
#(
  parameter int N = T_STATES_DEFAULT,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         legal
);

  // OR together the positions of set bits; exact only when the input is legal.
  always_comb begin
    idx   = '0;
    legal = (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = idx | W'(i);
    end
  end

endmodule

// File: rtl/tstate_ring.sv
// T-state ring counter for the SAP-1 controller: one-hot T1..TN sequencing
// with early end of cycle, halt at the next cycle boundary, illegal-state
// recovery and a completed-machine-cycle counter.
module tstate_ring
  import sap1_pkg::*;
#(
  parameter int N  = T_STATES_DEFAULT,
  parameter int CW = 16,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          early_end,
  input  logic          halt_req,
  output logic [N-1:0]  t,
  output logic [IW-1:0] t_idx,
  output logic          wrap,
  output logic          halted,
  output logic          err,
  output logic [CW-1:0] cyc_cnt
);

  logic          halt_pend;
  logic [IW-1:0] enc_idx;
  logic          enc_legal;

  ring_act_e     act;
  logic [N-1:0]  t_n;
  logic [IW-1:0] idx_n;
  logic          wrap_n;
  logic          err_n;
  logic          halted_n;
  logic          pend_n;
  logic [CW-1:0] cnt_n;

  onehot_enc #(.N(N), .W(IW)) u_enc (
    .vec   (t),
    .idx   (enc_idx),
    .legal (enc_legal)
  );

  // Pick the action for this edge; correction of a corrupt ring beats everything but reset.
  always_comb begin
    act = ACT_SHIFT;
    if (!enc_legal)                  act = ACT_FIX;
    else if (halted)                 act = ACT_HALTED;
    else if (!en)                    act = ACT_HOLD;
    else if (t[N-1] || early_end)    act = ACT_WRAP;
  end

  // Next-state values; flags default to 0 so they only ever pulse for one clock.
  always_comb begin
    t_n      = t;
    idx_n    = t_idx;
    wrap_n   = 1'b0;
    err_n    = 1'b0;
    halted_n = halted;
    cnt_n    = cyc_cnt;
    pend_n   = halt_pend | halt_req;
    case (act)
      ACT_FIX: begin
        t_n   = N'(1);
        idx_n = '0;
        err_n = 1'b1;
      end
      ACT_HALTED: begin
        t_n   = N'(1);
        idx_n = '0;
      end
      ACT_HOLD: ;
      ACT_WRAP: begin
        t_n    = N'(1);
        idx_n  = '0;
        wrap_n = 1'b1;
        cnt_n  = cyc_cnt + 1'b1;
        // The halt takes effect at the boundary, after the cycle is counted.
        if (halt_pend) begin
          halted_n = 1'b1;
          pend_n   = 1'b0;
        end
      end
      ACT_SHIFT: begin
        t_n   = {t[N-2:0], 1'b0};
        idx_n = enc_idx + 1'b1;
      end
      default: ;
    endcase
  end

  // Register every output plus the pending-halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      t         <= N'(1);
      t_idx     <= '0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      halted    <= 1'b0;
      halt_pend <= 1'b0;
      cyc_cnt   <= '0;
    end else begin
      t         <= t_n;
      t_idx     <= idx_n;
      wrap      <= wrap_n;
      err       <= err_n;
      halted    <= halted_n;
      halt_pend <= pend_n;
      cyc_cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_tstate_ring.sv
// Directed bench for tstate_ring (N=6, CW=16) with hand-computed expectations.
module tb_tstate_ring;

  logic        clk;
  logic        rst;
  logic        en;
  logic        early_end;
  logic        halt_req;
  logic [5:0]  t;
  logic [2:0]  t_idx;
  logic        wrap;
  logic        halted;
  logic        err;
  logic [15:0] cyc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  tstate_ring #(.N(6), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .early_end (early_end),
    .halt_req  (halt_req),
    .t         (t),
    .t_idx     (t_idx),
    .wrap      (wrap),
    .halted    (halted),
    .err       (err),
    .cyc_cnt   (cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_t"},      32'(t),       32'h01);
    check({tag, "_idx"},    32'(t_idx),   32'h0);
    check({tag, "_wrap"},   32'(wrap),    32'h0);
    check({tag, "_err"},    32'(err),     32'h0);
    check({tag, "_halted"}, 32'(halted),  32'h0);
    check({tag, "_cnt"},    32'(cyc_cnt), 32'h0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; early_end = 1'b0; halt_req = 1'b0;
    step();
    check_reset("rst");

    // Free-running: two full cycles.
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("seq_t",    32'(t),     32'(1) << (k % 6));
      check("seq_idx",  32'(t_idx), 32'(k % 6));
      check("seq_wrap", 32'(wrap),  (k % 6 == 0) ? 32'h1 : 32'h0);
    end
    check("seq_cnt", 32'(cyc_cnt), 32'd2);

    // Early end at T3.
    steps(2);
    check("ee_pre_t", 32'(t), 32'h04);
    early_end = 1'b1;
    step();
    early_end = 1'b0;
    check("ee_t",    32'(t),       32'h01);
    check("ee_idx",  32'(t_idx),   32'h0);
    check("ee_wrap", 32'(wrap),    32'h1);
    check("ee_cnt",  32'(cyc_cnt), 32'd3);

    // Hold mid-cycle.
    steps(2);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_t",    32'(t),       32'h04);
      check("hold_idx",  32'(t_idx),   32'h2);
      check("hold_wrap", 32'(wrap),    32'h0);
      check("hold_cnt",  32'(cyc_cnt), 32'd3);
    end
    en = 1'b1;

    // Halt request at T2, takes effect at the next wrap.
    steps(4);
    check("h_t1", 32'(t), 32'h01);
    check("h_cnt4", 32'(cyc_cnt), 32'd4);
    step();
    check("h_t2", 32'(t), 32'h02);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("h_t3", 32'(t), 32'h04);
    check("h_not_yet", 32'(halted), 32'h0);
    steps(3);
    check("h_t6", 32'(t), 32'h20);
    check("h_not_yet6", 32'(halted), 32'h0);
    step();
    check("h_t",      32'(t),       32'h01);
    check("h_wrap",   32'(wrap),    32'h1);
    check("h_halted", 32'(halted),  32'h1);
    check("h_cnt",    32'(cyc_cnt), 32'd5);
    for (int k = 0; k < 10; k++) begin
      step();
      check("hz_t",    32'(t),       32'h01);
      check("hz_cnt",  32'(cyc_cnt), 32'd5);
      check("hz_wrap", 32'(wrap),    32'h0);
    end
    check("hz_halted", 32'(halted), 32'h1);

    // Illegal state correction, with en low.
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    check_reset("rst2");
    @(negedge clk);
    force dut.t = 6'b001100;
    #1;
    release dut.t;
    step();
    check("ill_t",    32'(t),       32'h01);
    check("ill_idx",  32'(t_idx),   32'h0);
    check("ill_err",  32'(err),     32'h1);
    check("ill_wrap", 32'(wrap),    32'h0);
    check("ill_cnt",  32'(cyc_cnt), 32'h0);
    step();
    check("ill_err_clr", 32'(err), 32'h0);

    // Counter rollover via back-to-back zero-length cycles.
    en = 1'b1; early_end = 1'b1;
    steps(65535);
    check("roll_pre", 32'(cyc_cnt), 32'hFFFF);
    check("roll_pre_t", 32'(t), 32'h01);
    early_end = 1'b0;
    steps(5);
    check("roll_t6", 32'(t), 32'h20);
    step();
    check("roll_cnt",  32'(cyc_cnt), 32'h0);
    check("roll_wrap", 32'(wrap),    32'h1);

    // Reset at T4 beats early_end and halt_req on the same edge.
    steps(3);
    check("r4_t", 32'(t), 32'h08);
    rst = 1'b1; early_end = 1'b1; halt_req = 1'b1;
    step();
    rst = 1'b0; early_end = 1'b0; halt_req = 1'b0;
    check_reset("rst3");
    steps(6);
    check("post_wrap",   32'(wrap),    32'h1);
    check("post_halted", 32'(halted),  32'h0);
    check("post_cnt",    32'(cyc_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tstate_ring.md
TSTATE_RING -- requirements
Module: tstate_ring

Interface
REQ-001 Parameter N, default 6, number of T-states (legal range 2..16).
REQ-002 Parameter CW, default 16, width of the instruction-cycle counter.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-005 en  input  1  advance enable; 0 holds the current state.
REQ-006 early_end  input  1  when en=1, ends the current machine cycle and returns to T1 on the next edge.
REQ-007 halt_req  input  1  request to stop at the next T1 (SAP-1 HLT).
REQ-008 t  output  N  one-hot T-state; bit 0 is T1.
REQ-009 t_idx  output  $clog2(N)  binary index of the active T-state.
REQ-010 wrap  output  1  one-cycle flag; asserted while t returns to T1 after a completed or early-ended cycle.
REQ-011 halted  output  1  sticky; counter frozen at T1.
REQ-012 err  output  1  one-cycle flag; an illegal (non-one-hot) state was corrected.
REQ-013 cyc_cnt  output  CW  count of completed machine cycles; wraps modulo 2^CW.

Function
REQ-014 All outputs SHALL be registered; t_idx SHALL always be the encoded value of t.
REQ-015 The per-edge priority SHALL be: rst > illegal-state correction > halted > en=0 hold > wrap condition > shift.
REQ-016 Illegal state (t zero or more than one bit set) SHALL, regardless of en, load t=1 and t_idx=0, pulse err=1 and wrap=0, and leave cyc_cnt unchanged.
REQ-017 When halted=1, t SHALL stay at 1 and cyc_cnt SHALL stay unchanged; wrap=0; only rst clears halted.
REQ-018 en=0 SHALL hold t, t_idx, cyc_cnt and halted; wrap and err SHALL be 0.
REQ-019 The wrap condition is en=1 and (t[N-1]=1 or early_end=1); on it: t=1 next, wrap=1, cyc_cnt+1.
REQ-020 early_end while t=T1 SHALL keep t at T1, pulse wrap and increment cyc_cnt (zero-length cycle).
REQ-021 Otherwise, with en=1, t SHALL shift left by one, t_idx SHALL increment by one, and wrap=0.
REQ-022 halt_req SHALL be latched into an internal pending flag whenever it is 1, with en not required.
REQ-023 On a wrap edge with the flag pending, halted SHALL be set with t=1, wrap=1 and cyc_cnt+1; the pending flag is then cleared.
REQ-024 halt_req asserted while t=T1 and no wrap SHALL NOT halt until the next wrap.
REQ-025 cyc_cnt SHALL wrap from 2^CW-1 to 0 with no flag.
REQ-026 Latency: one clock from a sampled input to the corresponding output change.

Reset
REQ-027 On rst=1 at a clock edge: t=1, t_idx=0, wrap=0, err=0, halted=0, cyc_cnt=0, halt-pending cleared.
REQ-028 rst mid-cycle SHALL override every other input, including a simultaneous wrap, halt_req or illegal state.
REQ-029 The initial register content before the first rst is don't-care; the illegal-state path SHALL recover from it.

Structure
REQ-030 Shared package sap1_pkg SHALL hold T_STATES_DEFAULT=6 and the localparam function for the index width.
REQ-031 One sub-module onehot_enc (N-bit one-hot in -> binary index out, plus a legal flag) SHALL be instantiated.
REQ-032 All sequential state SHALL reside in tstate_ring; onehot_enc SHALL be purely combinational.

Verification (N=6, CW=16)
REQ-033 Reset, then en=1 for 12 clocks -> t sequence 000001..100000 twice; t_idx 0..5 twice; wrap on clocks 6 and 12; cyc_cnt=2.
REQ-034 en=1; early_end pulsed at T3 -> next t=000001, wrap=1, cyc_cnt+1; en=0 for 3 clocks mid-cycle -> t held, wrap=0.
REQ-035 halt_req pulsed at T2 -> counter runs to T6, then t=000001, wrap=1, halted=1; 10 more clocks with en=1 -> t unchanged, cyc_cnt unchanged.
REQ-036 Force t=001100 -> next edge t=000001, t_idx=0, err=1, cyc_cnt unchanged; the following clock err=0.
REQ-037 Preload cyc_cnt=16'hFFFF, complete one cycle -> cyc_cnt=0; rst asserted at T4 simultaneously with early_end and halt_req -> all reset values, halted=0.
